// File: rtl/video_decode_pkg.sv
// Shared types and constants for the scaler-facing video stream decoder.
package video_decode_pkg;

    localparam int unsigned WIDTH_W  = 10;
    localparam int unsigned SLOT_LSB = 13;
    localparam int unsigned SLOT_W   = 4;
    localparam int unsigned ERR_W    = 4;

    // Sticky error flag bit positions
    localparam int unsigned ERR_DE_GAP   = 0;
    localparam int unsigned ERR_HS_IN_DE = 1;
    localparam int unsigned ERR_VS_IN_DE = 2;
    localparam int unsigned ERR_OVERFLOW = 3;

    localparam logic [WIDTH_W-1:0] LINE_MAX = 10'd1023;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DE,
        ST_ACTIVE,
        ST_LINE_END,
        ST_WAIT_HS
    } state_t;

    // A slot word is clean when every bit outside the slot field is zero.
    function automatic logic slot_word_clean(input logic [23:0] word);
        return (word[23:SLOT_LSB+SLOT_W] == '0) && (word[SLOT_LSB-1:0] == '0);
    endfunction

endpackage

// File: rtl/video_line_meter.sv
// Per-line pixel counter with saturation, plus slot word capture/validation.
module video_line_meter
    import video_decode_pkg::*;
#(
    parameter logic [WIDTH_W-1:0] MAX_WIDTH = 10'd1023
) (
    input  logic               clk_vid,
    input  logic               reset,
    input  logic               load,
    input  logic               inc,
    input  logic               capture,
    input  logic               force_invalid,
    input  logic [23:0]        rgb_in,
    output logic               at_max,
    output logic [WIDTH_W-1:0] line_width,
    output logic [SLOT_W-1:0]  slot,
    output logic               slot_valid
);

    logic [WIDTH_W-1:0] count;

    assign at_max = (count == MAX_WIDTH);

    // Live pixel count: loads 1 on the first de cycle, then saturating increment.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= 10'd1;
        end else if (inc && !at_max) begin
            count <= count + 10'd1;
        end
    end

    // Publish width and slot word when the line closes.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            line_width <= '0;
            slot       <= '0;
            slot_valid <= 1'b0;
        end else if (capture) begin
            line_width <= count;
            slot       <= rgb_in[SLOT_LSB +: SLOT_W];
            slot_valid <= !force_invalid && slot_word_clean(rgb_in);
        end
    end

endmodule

// File: rtl/video_out_decoder.sv
// Receive-side decoder: line/frame FSM, frame line counter and sticky error flags.
module video_out_decoder
    import video_decode_pkg::*;
#(
    parameter logic [WIDTH_W-1:0] MAX_WIDTH = 10'd1023
) (
    input  logic               clk_vid,
    input  logic               reset,
    input  logic               vsync_in,
    input  logic               hsync_in,
    input  logic               de_in,
    input  logic [23:0]        rgb_in,
    input  logic               err_clear,
    output logic               line_done,
    output logic [WIDTH_W-1:0] line_width,
    output logic [SLOT_W-1:0]  slot,
    output logic               slot_valid,
    output logic               frame_done,
    output logic [WIDTH_W-1:0] frame_lines,
    output logic [ERR_W-1:0]   err_flags
);

    state_t             state, state_next;
    logic               meter_load, meter_inc, meter_capture, force_invalid;
    logic               publish, frame_close;
    logic               at_max;
    logic [ERR_W-1:0]   err_set;
    logic [WIDTH_W-1:0] line_count;

    video_line_meter #(
        .MAX_WIDTH(MAX_WIDTH)
    ) u_meter (
        .clk_vid       (clk_vid),
        .reset         (reset),
        .load          (meter_load),
        .inc           (meter_inc),
        .capture       (meter_capture),
        .force_invalid (force_invalid),
        .rgb_in        (rgb_in),
        .at_max        (at_max),
        .line_width    (line_width),
        .slot          (slot),
        .slot_valid    (slot_valid)
    );

    // State register.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control decode; vsync outranks every line event.
    always_comb begin
        state_next    = state;
        meter_load    = 1'b0;
        meter_inc     = 1'b0;
        meter_capture = 1'b0;
        force_invalid = 1'b0;
        publish       = 1'b0;
        frame_close   = 1'b0;
        err_set       = '0;

        if (state == ST_IDLE) begin
            if (vsync_in) begin
                state_next = ST_WAIT_HS;
            end
        end else if (vsync_in) begin
            frame_close = 1'b1;
            if (state == ST_ACTIVE) begin
                err_set[ERR_VS_IN_DE] = 1'b1;
            end
            state_next = hsync_in ? ST_WAIT_DE : ST_WAIT_HS;
        end else begin
            case (state)
                ST_WAIT_DE: begin
                    if (de_in && hsync_in) begin
                        err_set[ERR_HS_IN_DE] = 1'b1;
                    end else if (de_in) begin
                        meter_load = 1'b1;
                        state_next = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (de_in && hsync_in) begin
                        err_set[ERR_HS_IN_DE] = 1'b1;
                        meter_capture = 1'b1;
                        force_invalid = 1'b1;
                        publish       = 1'b1;
                        state_next    = ST_WAIT_DE;
                    end else if (de_in) begin
                        meter_inc = 1'b1;
                        err_set[ERR_OVERFLOW] = at_max;
                    end else begin
                        meter_capture = 1'b1;
                        publish       = 1'b1;
                        state_next    = hsync_in ? ST_WAIT_DE : ST_LINE_END;
                    end
                end
                ST_LINE_END, ST_WAIT_HS: begin
                    if (hsync_in) begin
                        err_set[ERR_HS_IN_DE] = de_in;
                        state_next = ST_WAIT_DE;
                    end else begin
                        err_set[ERR_DE_GAP] = de_in;
                        state_next = ST_WAIT_HS;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Line pulse and frame line counter; results land on the same edge as the meter capture.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            frame_lines <= '0;
            line_count  <= '0;
        end else begin
            line_done  <= publish;
            frame_done <= frame_close && (line_count != '0);
            if (frame_close) begin
                if (line_count != '0) begin
                    frame_lines <= line_count;
                end
                line_count <= '0;
            end else if (publish && (line_count != LINE_MAX)) begin
                line_count <= line_count + 10'd1;
            end
        end
    end

    // Sticky error flags; a fresh error in the clear cycle survives.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            err_flags <= '0;
        end else begin
            err_flags <= (err_clear ? '0 : err_flags) | err_set;
        end
    end

endmodule

// File: tb/tb_video_out_decoder.sv
module tb_video_out_decoder;

    logic        clk_vid = 1'b0;
    logic        reset;
    logic        vsync_in, hsync_in, de_in, err_clear;
    logic [23:0] rgb_in;
    logic        line_done, slot_valid, frame_done;
    logic [9:0]  line_width, frame_lines;
    logic [3:0]  slot, err_flags;

    int compared   = 0;
    int mismatched = 0;

    video_out_decoder #(.MAX_WIDTH(10'd1023)) dut (
        .clk_vid     (clk_vid),
        .reset       (reset),
        .vsync_in    (vsync_in),
        .hsync_in    (hsync_in),
        .de_in       (de_in),
        .rgb_in      (rgb_in),
        .err_clear   (err_clear),
        .line_done   (line_done),
        .line_width  (line_width),
        .slot        (slot),
        .slot_valid  (slot_valid),
        .frame_done  (frame_done),
        .frame_lines (frame_lines),
        .err_flags   (err_flags)
    );

    always #5 clk_vid = ~clk_vid;

    task automatic step();
        @(posedge clk_vid);
        #1;
    endtask

    // hsync, n de cycles, then the fall cycle carrying the slot word.
    task automatic send_line(input int n, input logic [23:0] word);
        hsync_in = 1'b1; step(); hsync_in = 1'b0;
        de_in = 1'b1; rgb_in = 24'h5A5A5A;
        repeat (n) step();
        de_in = 1'b0; rgb_in = word;
        step();
        rgb_in = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; vsync_in = 0; hsync_in = 0; de_in = 0; err_clear = 0; rgb_in = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        compared++;
        if ({line_done, line_width, slot, slot_valid, frame_done, frame_lines, err_flags} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got ld=%0b w=%0d s=%0d sv=%0b fd=%0b fl=%0d err=%b, want all 0",
                     line_done, line_width, slot, slot_valid, frame_done, frame_lines, err_flags);
        end
        send_line(5, 24'h004000);
        compared++;
        if (line_done !== 1'b0 || line_width !== 10'd0 || err_flags !== 4'b0) begin
            mismatched++;
            $display("FAIL idle_ignores: ld=%0b w=%0d err=%b, want 0 0 0000", line_done, line_width, err_flags);
        end
    endtask

    task automatic test_basic_line();
        vsync_in = 1; step(); vsync_in = 0;
        send_line(256, 24'h004000);
        compared++;
        if (line_done !== 1'b1 || line_width !== 10'd256 || slot !== 4'd2 || slot_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_line: ld=%0b w=%0d s=%0d sv=%0b, want 1 256 2 1", line_done, line_width, slot, slot_valid);
        end
        step();
        compared++;
        if (line_done !== 1'b0 || line_width !== 10'd256) begin
            mismatched++;
            $display("FAIL basic_hold: ld=%0b w=%0d, want 0 256", line_done, line_width);
        end
        vsync_in = 1; step(); vsync_in = 0;
        compared++;
        if (frame_done !== 1'b1 || frame_lines !== 10'd1) begin
            mismatched++;
            $display("FAIL basic_frame: fd=%0b fl=%0d, want 1 1", frame_done, frame_lines);
        end
    endtask

    task automatic test_frame();
        int bad = 0;
        for (int i = 0; i < 240; i++) begin
            send_line(120, 24'h000000);
            if (line_done !== 1'b1 || line_width !== 10'd120) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL frame_lines_each: %0d bad lines, want 0", bad);
        end
        vsync_in = 1; step(); vsync_in = 0;
        compared++;
        if (frame_done !== 1'b1 || frame_lines !== 10'd240 || err_flags !== 4'b0) begin
            mismatched++;
            $display("FAIL frame_240: fd=%0b fl=%0d err=%b, want 1 240 0000", frame_done, frame_lines, err_flags);
        end
        step();
        compared++;
        if (frame_done !== 1'b0 || frame_lines !== 10'd240) begin
            mismatched++;
            $display("FAIL frame_hold: fd=%0b fl=%0d, want 0 240", frame_done, frame_lines);
        end
    endtask

    task automatic test_slot_invalid();
        send_line(10, 24'h008001);
        compared++;
        if (line_done !== 1'b1 || slot !== 4'd4 || slot_valid !== 1'b0 || line_width !== 10'd10) begin
            mismatched++;
            $display("FAIL slot_invalid: ld=%0b s=%0d sv=%0b w=%0d, want 1 4 0 10", line_done, slot, slot_valid, line_width);
        end
    endtask

    task automatic test_overflow();
        send_line(1100, 24'h000000);
        compared++;
        if (line_width !== 10'd1023 || err_flags !== 4'b1000) begin
            mismatched++;
            $display("FAIL overflow: w=%0d err=%b, want 1023 1000", line_width, err_flags);
        end
        err_clear = 1; step(); err_clear = 0;
        compared++;
        if (err_flags !== 4'b0000) begin
            mismatched++;
            $display("FAIL err_clear: err=%b, want 0000", err_flags);
        end
    endtask

    task automatic test_vsync_midline();
        hsync_in = 1; step(); hsync_in = 0;
        de_in = 1; repeat (100) step();
        vsync_in = 1; step(); vsync_in = 0; de_in = 0;
        compared++;
        if (line_done !== 1'b0 || frame_done !== 1'b1 || frame_lines !== 10'd2 ||
            err_flags !== 4'b0100 || line_width !== 10'd1023) begin
            mismatched++;
            $display("FAIL vsync_midline: ld=%0b fd=%0b fl=%0d err=%b w=%0d, want 0 1 2 0100 1023",
                     line_done, frame_done, frame_lines, err_flags, line_width);
        end
        step();
        err_clear = 1; step(); err_clear = 0;
        send_line(5, 24'h000000);
        vsync_in = 1; step(); vsync_in = 0;
        compared++;
        if (frame_done !== 1'b1 || frame_lines !== 10'd1 || err_flags !== 4'b0) begin
            mismatched++;
            $display("FAIL vsync_restart: fd=%0b fl=%0d err=%b, want 1 1 0000", frame_done, frame_lines, err_flags);
        end
    endtask

    task automatic test_de_gap();
        send_line(20, 24'h000000);
        compared++;
        if (line_done !== 1'b1 || line_width !== 10'd20) begin
            mismatched++;
            $display("FAIL gap_first: ld=%0b w=%0d, want 1 20", line_done, line_width);
        end
        repeat (2) step();
        de_in = 1; repeat (10) step();
        de_in = 0; step();
        compared++;
        if (err_flags !== 4'b0001 || line_done !== 1'b0 || line_width !== 10'd20) begin
            mismatched++;
            $display("FAIL de_gap: err=%b ld=%0b w=%0d, want 0001 0 20", err_flags, line_done, line_width);
        end
    endtask

    task automatic test_vsync_hsync();
        err_clear = 1; step(); err_clear = 0;
        vsync_in = 1; hsync_in = 1; step(); vsync_in = 0; hsync_in = 0;
        compared++;
        if (frame_done !== 1'b1 || frame_lines !== 10'd1 || err_flags !== 4'b0) begin
            mismatched++;
            $display("FAIL vs_hs_close: fd=%0b fl=%0d err=%b, want 1 1 0000", frame_done, frame_lines, err_flags);
        end
        de_in = 1; repeat (7) step();
        de_in = 0; step();
        compared++;
        if (line_done !== 1'b1 || line_width !== 10'd7) begin
            mismatched++;
            $display("FAIL vs_hs_line: ld=%0b w=%0d, want 1 7", line_done, line_width);
        end
        vsync_in = 1; step(); vsync_in = 0;
        compared++;
        if (frame_done !== 1'b1 || frame_lines !== 10'd1) begin
            mismatched++;
            $display("FAIL vs_hs_count: fd=%0b fl=%0d, want 1 1", frame_done, frame_lines);
        end
    endtask

    task automatic test_hsync_during_de();
        hsync_in = 1; step(); hsync_in = 0;
        de_in = 1; repeat (30) step();
        hsync_in = 1; rgb_in = 24'h004000; step(); hsync_in = 0; rgb_in = '0;
        compared++;
        if (line_done !== 1'b1 || line_width !== 10'd30 || slot !== 4'd2 ||
            slot_valid !== 1'b0 || err_flags !== 4'b0010) begin
            mismatched++;
            $display("FAIL hs_in_de: ld=%0b w=%0d s=%0d sv=%0b err=%b, want 1 30 2 0 0010",
                     line_done, line_width, slot, slot_valid, err_flags);
        end
        repeat (4) step();
        de_in = 0; rgb_in = 24'h00A000; step(); rgb_in = '0;
        compared++;
        if (line_done !== 1'b1 || line_width !== 10'd4 || slot !== 4'd5 || slot_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL back_to_back: ld=%0b w=%0d s=%0d sv=%0b, want 1 4 5 1", line_done, line_width, slot, slot_valid);
        end
    endtask

    task automatic test_reset_midline();
        hsync_in = 1; step(); hsync_in = 0;
        de_in = 1; repeat (50) step();
        reset = 1; #1;
        compared++;
        if ({line_done, line_width, slot, slot_valid, frame_done, frame_lines, err_flags} !== '0) begin
            mismatched++;
            $display("FAIL reset_midline: ld=%0b w=%0d s=%0d sv=%0b fd=%0b fl=%0d err=%b, want all 0",
                     line_done, line_width, slot, slot_valid, frame_done, frame_lines, err_flags);
        end
        step(); reset = 0;
        de_in = 0; step();
        send_line(3, 24'h000000);
        compared++;
        if (line_done !== 1'b0 || line_width !== 10'd0 || err_flags !== 4'b0) begin
            mismatched++;
            $display("FAIL post_reset_idle: ld=%0b w=%0d err=%b, want 0 0 0000", line_done, line_width, err_flags);
        end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_frame();
        test_slot_invalid();
        test_overflow();
        test_vsync_midline();
        test_de_gap();
        test_vsync_hsync();
        test_hsync_during_de();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
